// File: rtl/l2_mem_ctrl_pkg.sv
// Shared types and constants for the L2 backing-memory controller.
// Round-robin arbitration is enabled by defining L2_MEM_RR_ARB_EN.
package l2_mem_pkg;

    localparam int LINE_W  = 128;
    localparam int ADDR_W  = 14;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = 13;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/l2_mem_ctrl_if.sv
// Two-port line refill/write-back bus between cache_l2 (master) and l2_mem_ctrl (slave).
interface l2_mem_ctrl_if;
    import l2_mem_pkg::*;

    logic              mem_valid1;
    logic              mem_rd_wr1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [LINE_W-1:0] mem_din1;
    logic [LINE_W-1:0] mem_dout1;
    logic              mem_ack1;

    logic              mem_valid2;
    logic              mem_rd_wr2;
    logic [ADDR_W-1:0] mem_addr2;
    logic [LINE_W-1:0] mem_din2;
    logic [LINE_W-1:0] mem_dout2;
    logic              mem_ack2;

    logic              mem_busy;

    modport master (
        output mem_valid1, mem_rd_wr1, mem_addr1, mem_din1,
        output mem_valid2, mem_rd_wr2, mem_addr2, mem_din2,
        input  mem_dout1, mem_ack1, mem_dout2, mem_ack2, mem_busy
    );

    modport slave (
        input  mem_valid1, mem_rd_wr1, mem_addr1, mem_din1,
        input  mem_valid2, mem_rd_wr2, mem_addr2, mem_din2,
        output mem_dout1, mem_ack1, mem_dout2, mem_ack2, mem_busy
    );

endinterface

// File: rtl/l2_mem_ctrl_arb.sv
// Two-request arbiter: fixed port-1 priority by default, round-robin when
// L2_MEM_RR_ARB_EN is defined.
module l2_mem_arb (
`ifdef L2_MEM_RR_ARB_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en_i,
    input  logic req1_i,
    input  logic req2_i,
    output logic gnt1_o,
    output logic gnt2_o
);

`ifdef L2_MEM_RR_ARB_EN
    logic prio2_q;

    always_comb begin
        gnt1_o = 1'b0;
        gnt2_o = 1'b0;
        if (en_i) begin
            if (req1_i && req2_i) begin
                gnt1_o = ~prio2_q;
                gnt2_o = prio2_q;
            end else begin
                gnt1_o = req1_i;
                gnt2_o = req2_i;
            end
        end
    end

    // The pointer moves away from whichever port just won, abandoned or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio2_q <= 1'b0;
        end else if (gnt1_o) begin
            prio2_q <= 1'b1;
        end else if (gnt2_o) begin
            prio2_q <= 1'b0;
        end
    end
`else
    always_comb begin
        gnt1_o = en_i & req1_i;
        gnt2_o = en_i & req2_i & ~req1_i;
    end
`endif

endmodule

// File: rtl/l2_mem_ctrl.sv
// Fixed-latency single-ported line memory serving the two L2 ports.
// Build option: L2_MEM_RR_ARB_EN selects round-robin arbitration.
module l2_mem_ctrl
    import l2_mem_pkg::*;
#(
    parameter int DEPTH   = 3072,
    parameter int LATENCY = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    l2_mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt2_q, gnt2_d;
    logic              rdWr_q, rdWr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] din_q, din_d;
    logic              abandon_q, abandon_d;
    logic              ack1_q, ack1_d;
    logic              ack2_q, ack2_d;
    logic [LINE_W-1:0] dout1_q, dout1_d;
    logic [LINE_W-1:0] dout2_q, dout2_d;

    logic [LINE_W-1:0] mem_q [DEPTH];

    logic gnt1, gnt2;
    logic grantedValid;
    logic inRange;
    logic doAccess;
    logic [LINE_W-1:0] rdData;
    logic unusedAddrBits;

    assign unusedAddrBits = ^{bus.mem_addr1[IDX_LSB-1:0], bus.mem_addr2[IDX_LSB-1:0]};

    l2_mem_arb uArb (
`ifdef L2_MEM_RR_ARB_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .en_i   (state_q == IDLE),
        .req1_i (bus.mem_valid1),
        .req2_i (bus.mem_valid2),
        .gnt1_o (gnt1),
        .gnt2_o (gnt2)
    );

    assign grantedValid = gnt2_q ? bus.mem_valid2 : bus.mem_valid1;
    assign inRange      = (int'({20'd0, idx_q}) < DEPTH);
    assign rdData       = inRange ? mem_q[idx_q] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt2_d    = gnt2_q;
        rdWr_d    = rdWr_q;
        idx_d     = idx_q;
        din_d     = din_q;
        abandon_d = abandon_q;
        ack1_d    = ack1_q;
        ack2_d    = ack2_q;
        dout1_d   = dout1_q;
        dout2_d   = dout2_q;
        doAccess  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt1 || gnt2) begin
                    state_d   = WAIT;
                    gnt2_d    = gnt2;
                    rdWr_d    = gnt2 ? bus.mem_rd_wr2 : bus.mem_rd_wr1;
                    idx_d     = gnt2 ? bus.mem_addr2[IDX_MSB:IDX_LSB]
                                     : bus.mem_addr1[IDX_MSB:IDX_LSB];
                    din_d     = gnt2 ? bus.mem_din2 : bus.mem_din1;
                    cnt_d     = '0;
                    abandon_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!grantedValid) begin
                    abandon_d = 1'b1;
                end
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    doAccess = 1'b1;
                    if (!rdWr_q) begin
                        if (gnt2_q) dout2_d = rdData;
                        else        dout1_d = rdData;
                    end
                    // A request dropped at any point in WAIT completes silently.
                    if (abandon_q || !grantedValid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACK;
                        ack1_d  = ~gnt2_q;
                        ack2_d  = gnt2_q;
                    end
                end
            end
            ACK: begin
                if (!grantedValid) begin
                    state_d = IDLE;
                    ack1_d  = 1'b0;
                    ack2_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt2_q    <= 1'b0;
            rdWr_q    <= 1'b0;
            idx_q     <= '0;
            din_q     <= '0;
            abandon_q <= 1'b0;
            ack1_q    <= 1'b0;
            ack2_q    <= 1'b0;
            dout1_q   <= '0;
            dout2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt2_q    <= gnt2_d;
            rdWr_q    <= rdWr_d;
            idx_q     <= idx_d;
            din_q     <= din_d;
            abandon_q <= abandon_d;
            ack1_q    <= ack1_d;
            ack2_q    <= ack2_d;
            dout1_q   <= dout1_d;
            dout2_q   <= dout2_d;
        end
    end

    // The array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (doAccess && rdWr_q && inRange) begin
            mem_q[idx_q] <= din_q;
        end
    end

    assign bus.mem_dout1 = dout1_q;
    assign bus.mem_dout2 = dout2_q;
    assign bus.mem_ack1  = ack1_q;
    assign bus.mem_ack2  = ack2_q;
    assign bus.mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Directed self-checking bench for l2_mem_ctrl (LATENCY=16); expected
// arbitration order follows L2_MEM_RR_ARB_EN.
module tb_l2_mem_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    l2_mem_ctrl_if bus ();

    l2_mem_ctrl #(
        .DEPTH   (3072),
        .LATENCY (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    localparam logic [127:0] DATA_A5   = {16{8'hA5}};
    localparam logic [127:0] DATA_DEAD = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5ADEAD;
    localparam logic [127:0] DATA_P1   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] DATA_P2   = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] DATA_OLD7 = 128'h0707_0707_0707_0707_0707_0707_0707_0707;
    localparam logic [127:0] DATA_NEW7 = 128'hF7F7_0000_F7F7_0000_F7F7_0000_F7F7_0000;
    localparam logic [127:0] DATA_Z0   = 128'hC0FFEE00_00000000_00000000_0000000A;
    localparam logic [127:0] DATA_Z1   = 128'hC0FFEE00_00000000_00000000_0000000B;
    localparam logic [127:0] DATA_BAD  = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    localparam logic [127:0] DATA_OLD9 = 128'h99990000_99990000_99990000_99990000;
    localparam logic [127:0] DATA_NEW9 = 128'h00009999_00009999_00009999_00009999;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic rdWr,
                                 input logic [13:0] addr, input logic [127:0] din);
        if (port == 1) begin
            bus.mem_valid1 = valid;
            bus.mem_rd_wr1 = rdWr;
            bus.mem_addr1  = addr;
            bus.mem_din1   = din;
        end else begin
            bus.mem_valid2 = valid;
            bus.mem_rd_wr2 = rdWr;
            bus.mem_addr2  = addr;
            bus.mem_din2   = din;
        end
    endtask

    // Called right after a negedge with the controller idle; returns after ack has cleared.
    task automatic doTxn(input string tag, input int port, input logic rdWr,
                         input logic [13:0] addr, input logic [127:0] din,
                         output logic [127:0] rdata);
        int   cyc;
        logic got;
        cyc = 0;
        got = 1'b0;
        applyStimulus(port, 1'b1, rdWr, addr, din);
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            got = (port == 1) ? bus.mem_ack1 : bus.mem_ack2;
        end
        checkOutput({tag, "_latency"}, 128'(cyc), 128'd17);
        rdata = (port == 1) ? bus.mem_dout1 : bus.mem_dout2;
        checkOutput({tag, "_other_ack"}, 128'((port == 1) ? bus.mem_ack2 : bus.mem_ack1), 128'd0);
        @(negedge clk);
        checkOutput({tag, "_ack_held"}, 128'((port == 1) ? bus.mem_ack1 : bus.mem_ack2), 128'd1);
        applyStimulus(port, 1'b0, rdWr, addr, din);
        @(negedge clk);
        checkOutput({tag, "_ack_fall"}, 128'((port == 1) ? bus.mem_ack1 : bus.mem_ack2), 128'd0);
        checkOutput({tag, "_busy_idle"}, 128'(bus.mem_busy), 128'd0);
    endtask

    initial begin
        logic [127:0] rd;
        logic [127:0] doutHold;
        logic         ackSeen;
        int           cyc;
        int           winner;
        int           expWin;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 14'h0, 128'h0);
        applyStimulus(2, 1'b0, 1'b0, 14'h0, 128'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ack1",  128'(bus.mem_ack1), 128'd0);
        checkOutput("rst_ack2",  128'(bus.mem_ack2), 128'd0);
        checkOutput("rst_busy",  128'(bus.mem_busy), 128'd0);
        checkOutput("rst_dout1", bus.mem_dout1, 128'd0);
        checkOutput("rst_dout2", bus.mem_dout2, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on port 1 after preloading line 5.
        doTxn("pre5", 1, 1'b1, 14'h0014, DATA_A5, rd);
        doTxn("rd5", 1, 1'b0, 14'h0014, 128'h0, rd);
        checkOutput("rd5_data", rd, DATA_A5);

        // Write-then-read on port 2; the write must not touch dout2.
        doTxn("rd5p2", 2, 1'b0, 14'h0014, 128'h0, rd);
        checkOutput("rd5p2_data", rd, DATA_A5);
        doTxn("wr100", 2, 1'b1, 14'h0100, DATA_DEAD, rd);
        checkOutput("wr100_dout2_hold", bus.mem_dout2, DATA_A5);
        checkOutput("wr100_dout1_hold", bus.mem_dout1, DATA_A5);
        doTxn("rd100", 2, 1'b0, 14'h0100, 128'h0, rd);
        checkOutput("rd100_data", rd, DATA_DEAD);

        // Simultaneous reads, each port re-requesting after its own ack.
        doTxn("pre10", 1, 1'b1, 14'h0028, DATA_P1, rd);
        doTxn("pre11", 2, 1'b1, 14'h002C, DATA_P2, rd);
        applyStimulus(1, 1'b1, 1'b0, 14'h0028, 128'h0);
        applyStimulus(2, 1'b1, 1'b0, 14'h002C, 128'h0);
        for (int r = 0; r < 4; r++) begin
            cyc = 0;
            while (!(bus.mem_ack1 || bus.mem_ack2) && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            winner = bus.mem_ack1 ? 1 : (bus.mem_ack2 ? 2 : 0);
`ifdef L2_MEM_RR_ARB_EN
            expWin = (r % 2 == 0) ? 1 : 2;
`else
            expWin = 1;
`endif
            checkOutput("arb_winner", 128'(winner), 128'(expWin));
            checkOutput("arb_latency", 128'(cyc), 128'd17);
            checkOutput("arb_single_ack", 128'(bus.mem_ack1 & bus.mem_ack2), 128'd0);
            checkOutput("arb_data", (winner == 2) ? bus.mem_dout2 : bus.mem_dout1,
                        (expWin == 2) ? DATA_P2 : DATA_P1);
            if (winner == 1) bus.mem_valid1 = 1'b0;
            if (winner == 2) bus.mem_valid2 = 1'b0;
            @(negedge clk);
            if (r < 3) begin
                if (winner == 1) bus.mem_valid1 = 1'b1;
                if (winner == 2) bus.mem_valid2 = 1'b1;
            end
        end
        bus.mem_valid1 = 1'b0;
        bus.mem_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("arb_idle_busy", 128'(bus.mem_busy), 128'd0);

        // Abandoned write to line 7: valid sampled low at E0+5.
        doTxn("pre7", 1, 1'b1, 14'h001C, DATA_OLD7, rd);
        ackSeen = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 14'h001C, DATA_NEW7);
        for (int p = 1; p <= 25; p++) begin
            @(negedge clk);
            if (bus.mem_ack1) ackSeen = 1'b1;
            if (p == 5) applyStimulus(1, 1'b0, 1'b1, 14'h001C, DATA_NEW7);
            if (p == 16) checkOutput("abandon_busy_e15", 128'(bus.mem_busy), 128'd1);
            if (p == 17) checkOutput("abandon_busy_e16", 128'(bus.mem_busy), 128'd0);
        end
        checkOutput("abandon_no_ack", 128'(ackSeen), 128'd0);
        doTxn("rd7", 1, 1'b0, 14'h001C, 128'h0, rd);
        checkOutput("rd7_data", rd, DATA_NEW7);

        // Out-of-range index 3072.
        doTxn("pre0", 1, 1'b1, 14'h0000, DATA_Z0, rd);
        doTxn("pre1024", 1, 1'b1, 14'h1000, DATA_Z1, rd);
        doTxn("rd1024", 1, 1'b0, 14'h1000, 128'h0, rd);
        checkOutput("rd1024_data", rd, DATA_Z1);
        doTxn("oor_rd", 1, 1'b0, 14'h3000, 128'h0, rd);
        checkOutput("oor_rd_data", rd, 128'h0);
        doTxn("oor_wr", 1, 1'b1, 14'h3000, DATA_BAD, rd);
        doTxn("rd0", 1, 1'b0, 14'h0000, 128'h0, rd);
        checkOutput("oor_line0", rd, DATA_Z0);
        doTxn("rd1024b", 2, 1'b0, 14'h1000, 128'h0, rd);
        checkOutput("oor_line1024", rd, DATA_Z1);

        // Reset in the middle of a write to line 9.
        doTxn("pre9", 1, 1'b1, 14'h0024, DATA_OLD9, rd);
        doutHold = bus.mem_dout2;
        checkOutput("pre_reset_dout2", doutHold, DATA_Z1);
        applyStimulus(1, 1'b1, 1'b1, 14'h0024, DATA_NEW9);
        for (int p = 1; p <= 8; p++) begin
            @(negedge clk);
        end
        checkOutput("pre_reset_busy", 128'(bus.mem_busy), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack1",  128'(bus.mem_ack1), 128'd0);
        checkOutput("midrst_busy",  128'(bus.mem_busy), 128'd0);
        checkOutput("midrst_dout1", bus.mem_dout1, 128'd0);
        checkOutput("midrst_dout2", bus.mem_dout2, 128'd0);
        applyStimulus(1, 1'b0, 1'b0, 14'h0, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        doTxn("rd9", 1, 1'b0, 14'h0024, 128'h0, rd);
        checkOutput("rd9_old_kept", rd, DATA_OLD9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_mem_ctrl.md
# l2_mem_ctrl

Backing-memory controller directly downstream of `cache_l2`. It serves the L2's two line-refill/write-back ports (port 1, port 2) from a single-ported array of 128-bit lines with a fixed access latency. It arbitrates between the two ports and holds each port's ack until that port drops valid. It replaces the ad-hoc counter/array memory model in the top level with a reusable, synthesizable block.

## Interface
- `DEPTH`, 3072: number of 128-bit lines.
- `LATENCY`, 16: cycles from grant to data/ack; legal range 1..31.
- `AW`, 14: request address width.
- `DW`, 128: line width.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `mem_valid1` / `mem_valid2` in 1: request from port n; held high until ack is seen.
- `mem_rd_wr1` / `mem_rd_wr2` in 1: 1 = write line, 0 = read line.
- `mem_addr1` / `mem_addr2` in AW: line address; index = addr[13:2].
- `mem_din1` / `mem_din2` in DW: write data.
- `mem_dout1` / `mem_dout2` out DW: read data, registered; reset 0.
- `mem_ack1` / `mem_ack2` out 1: completion, registered; reset 0.
- `mem_busy` out 1: access in progress (any state except IDLE); reset 0.

## Operation
- FSM states:
  - IDLE: at an edge with any valid high, grant one port. Latch rd_wr, index, and din; clear the counter; go to WAIT.
  - WAIT: the counter increments each cycle. The edge where the counter reaches LATENCY-1 performs the array access and goes to ACK.
    - Write: array[index] <= din.
    - Read: granted dout <= array[index].
  - ACK: the granted ack stays high while the granted valid is high. At the edge where the granted valid is sampled low, ack clears and the FSM goes to IDLE.
- Arbitration: only in IDLE. Without the `_EN` macro, port 1 has fixed priority. With the macro, round-robin (see Configuration).
- A granted request is committed. If the granted valid drops during WAIT, the access still executes but ack is not raised, and the FSM returns to IDLE after the access edge.
- Out-of-range index (index >= DEPTH): write dropped; read returns all zeros; ack behaviour unchanged.
- Ports:
  - The non-granted port's ack stays 0.
  - Its dout holds its last read value.
  - Writes never alter dout.
- Reset mid-operation:
  - Outputs return to 0 and the FSM to IDLE.
  - A pending write in WAIT is lost.
  - Array contents are not cleared by reset.
- Array initial contents are undefined unless loaded by the bench.

## Timing
- Valid sampled in IDLE at edge E0 (grant). Array access, dout update, and ack rise all occur at edge E0+LATENCY; LATENCY=16 gives ack 16 cycles after grant.
- Ack falls at the first edge where the granted valid is sampled low.
- IDLE lasts at least one cycle between transactions, so back-to-back grants are spaced at least LATENCY+2 cycles.
- Counter width is 5 bits; it never wraps within legal LATENCY.
- Simultaneous valids in IDLE: exactly one grant. The loser waits in IDLE arbitration until the next free IDLE edge.

## Configuration
- `L2_MEM_RR_ARB_EN` defined: round-robin.
  - Priority pointer toggles to the other port after each granted transaction, including abandoned ones.
  - Reset value favours port 1.
- Undefined: fixed priority, port 1 always wins simultaneous requests; port 2 can starve.

## Structure
- Package `l2_mem_pkg`: state encoding (IDLE, WAIT, ACK), LINE_W=128, ADDR_W=14, index slice constants.
- Sub-module `l2_mem_arb`: two-request arbiter, grant-enable input, pointer register under the macro. Everything else is in `l2_mem_ctrl`.

## Test plan
- Single read, port 1: preload line 5 = 0x…A5; valid1 with rd_wr=0, addr=0x0014. Expect ack1 and dout1=0x…A5 at E0+16; ack1 held until valid1 falls, then low next edge.
- Write-then-read, port 2: write 0x1234…DEAD to addr 0x0100, then read the same line. Expect read data = written data; dout2 unchanged by the write.
- Simultaneous valid1/valid2 reads, repeated 4 times:
  - Fixed priority: all grants to port 1 while it re-requests.
  - `L2_MEM_RR_ARB_EN`: grants alternate 1,2,1,2.
- Abandon: drop valid1 at E0+5 on a write to line 7. Expect ack1 never rises; line 7 holds the new data; busy low after E0+16.
- Out-of-range: read index 3072 (addr 0x3000). Expect dout=0 with normal ack. A write to index 3072 leaves all lines unchanged.
- Reset asserted at E0+8 during a write: ack/busy/dout go 0 immediately; the target line retains its old value; a new request after release is served normally.
